seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It scans `NUM_DIGITS` hex digits onto one shared active-low segment bus, one digit per slot. Each slot starts with a blanking interval to prevent ghosting, and a frame-coherent input snapshot prevents tearing. It sits between the application's hex-value registers and the board's segment and anode pins, and replaces per-digit static decoding.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_lut.sv | 12 +
 rtl/seven_seg_scanner.sv | 128 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner:
// active-low hex glyphs, blank pattern and scan phase type.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = hex value; bit 6 = a ... bit 0 = g, 0 lights a segment.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    BLANK,
    DRIVE
  } phase_t;

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex to active-low seven-segment glyph lookup.
// Pure table read, no state.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with
// per-slot blanking and a frame-coherent input snapshot.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 2,
  parameter int SLOT_CYCLES      = 24000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IW-1:0]           digit_idx
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BEND = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  phase_t                  phase;
  logic [4*NUM_DIGITS-1:0] dig_s;
  logic [NUM_DIGITS-1:0]   en_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic                    lz_s;

  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  zrun;
  logic [3:0]            cur_hex;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_supp;
  logic [6:0]            cur_glyph;
  logic                  lit;

  // Suppress digit i when it and every higher digit is zero.
  always_comb begin
    supp = '0;
    zrun = lz_s;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun    = zrun && (dig_s[4*i +: 4] == 4'h0);
      supp[i] = zrun;
    end
  end

  always_comb begin
    cur_hex  = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_hex   = dig_s[4*i +: 4];
        cur_en    = en_s[i];
        cur_dp    = dp_s[i];
        cur_supp  = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  seg_hex_lut u_lut (
    .hex (cur_hex),
    .seg (cur_glyph)
  );

  assign lit = (phase == DRIVE) && cur_en && !cur_supp;

  // cnt/idx/phase name the position being emitted at the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      phase     <= BLANK;
      dig_s     <= '0;
      en_s      <= '0;
      dp_s      <= '0;
      lz_s      <= 1'b0;
      seg       <= SEG_BLANK;
      dp_n      <= 1'b1;
      anode     <= AN_OFF;
      digit_idx <= '0;
    end else begin
      digit_idx <= idx;
      if (cnt == '0 && idx == '0) begin
        dig_s <= digits;
        en_s  <= digit_en;
        dp_s  <= dp;
        lz_s  <= lz_suppress;
      end
      if (lit) begin
        seg   <= cur_glyph;
        dp_n  <= ~cur_dp;
        anode <= onehot ^ AN_OFF;
      end else begin
        seg   <= SEG_BLANK;
        dp_n  <= 1'b1;
        anode <= AN_OFF;
      end
      unique case (phase)
        BLANK: if (cnt == CNT_BEND) phase <= DRIVE;
        DRIVE: if (cnt == CNT_LAST) phase <= BLANK;
        default: phase <= BLANK;
      endcase
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 2 digits,
// 8-cycle slots and 2 blank cycles.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] digits;
  logic [1:0] digit_en;
  logic [1:0] dp;
  logic       lz_suppress;
  logic [6:0] seg;
  logic       dp_n;
  logic [1:0] anode;
  logic [0:0] digit_idx;

  int total  = 0;
  int passed = 0;
  int pos    = 0;

  seven_seg_scanner #(
    .NUM_DIGITS       (2),
    .SLOT_CYCLES      (8),
    .BLANK_CYCLES     (2),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .digit_en    (digit_en),
    .dp          (dp),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp_n        (dp_n),
    .anode       (anode),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] digits;
    logic [1:0] en;
    logic [1:0] dp;
    logic       lz;
    logic [1:0] an0;
    logic [6:0] seg0;
    logic       dpn0;
    logic [1:0] an1;
    logic [6:0] seg1;
    logic       dpn1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int p,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s pos=%0d got=%h want=%h", name, p, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos++;
  endtask

  // Hold reset with the given inputs, release on a falling edge.
  // After tick() #k the sampled outputs belong to position k-1.
  task automatic restart(input logic [7:0] d, input logic [1:0] en,
                         input logic [1:0] p, input logic lz);
    @(negedge clk);
    reset       = 1'b0;
    digits      = d;
    digit_en    = en;
    dp          = p;
    lz_suppress = lz;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pos   = -1;
  endtask

  task automatic go_to(input int p);
    while (pos < p) tick();
  endtask

  function automatic logic [15:0] pack_out();
    return {anode, seg, dp_n, digit_idx, 5'b0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog pos=%0d got=timeout want=finish", pos);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h3A, 2'b11, 2'b10, 1'b0,
                2'b10, 7'b0001000, 1'b1, 2'b01, 7'b0000110, 1'b0};
    vecs[1] = '{8'h05, 2'b11, 2'b00, 1'b1,
                2'b10, 7'b0100100, 1'b1, 2'b11, 7'h7F, 1'b1};
    vecs[2] = '{8'h00, 2'b11, 2'b00, 1'b1,
                2'b10, 7'b0000001, 1'b1, 2'b11, 7'h7F, 1'b1};
    vecs[3] = '{8'h00, 2'b11, 2'b00, 1'b0,
                2'b10, 7'b0000001, 1'b1, 2'b01, 7'b0000001, 1'b1};
    vecs[4] = '{8'hC9, 2'b01, 2'b11, 1'b0,
                2'b10, 7'b0001100, 1'b0, 2'b11, 7'h7F, 1'b1};
    vecs[5] = '{8'hF8, 2'b10, 2'b01, 1'b0,
                2'b11, 7'h7F, 1'b1, 2'b01, 7'b0111000, 1'b1};
    vecs[6] = '{8'hB6, 2'b11, 2'b01, 1'b1,
                2'b10, 7'b0100000, 1'b0, 2'b01, 7'b1100000, 1'b1};
    vecs[7] = '{8'h04, 2'b00, 2'b11, 1'b1,
                2'b11, 7'h7F, 1'b1, 2'b11, 7'h7F, 1'b1};
    vecs[8] = '{8'hD2, 2'b11, 2'b00, 1'b1,
                2'b10, 7'b0010010, 1'b1, 2'b01, 7'b1000010, 1'b1};
    vecs[9] = '{8'h71, 2'b11, 2'b11, 1'b0,
                2'b10, 7'b1001111, 1'b0, 2'b01, 7'b0001111, 1'b0};

    reset = 1'b0;
    digits = 8'h00;
    digit_en = 2'b00;
    dp = 2'b00;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", -1, pack_out(), {2'b11, 7'h7F, 1'b1, 1'b0, 5'b0});

    // Scenario 1: anode sequence after release.
    restart(8'h3A, 2'b11, 2'b00, 1'b0);
    for (int p = 0; p < 16; p++) begin
      go_to(p);
      chk("rel_anode", p, anode,
          (p >= 2 && p <= 7) ? 2'b10 :
          (p >= 10) ? 2'b01 : 2'b11);
    end
    chk("rel_idx", pos, digit_idx, 1'b1);

    // Table: one frame per vector, mid-DRIVE of each slot.
    for (int v = 0; v < 10; v++) begin
      restart(vecs[v].digits, vecs[v].en, vecs[v].dp, vecs[v].lz);
      go_to(1);
      chk("vec_blank", v, pack_out(), {2'b11, 7'h7F, 1'b1, 1'b0, 5'b0});
      go_to(4);
      chk("vec_slot0", v, pack_out(),
          {vecs[v].an0, vecs[v].seg0, vecs[v].dpn0, 1'b0, 5'b0});
      go_to(12);
      chk("vec_slot1", v, pack_out(),
          {vecs[v].an1, vecs[v].seg1, vecs[v].dpn1, 1'b1, 5'b0});
    end

    // Scenario 3: mid-frame change waits for the next frame.
    restart(8'h3A, 2'b11, 2'b00, 1'b0);
    go_to(3);
    digits = 8'h77;
    go_to(12);
    chk("midframe_s1", pos, seg, 7'b0000110);
    go_to(20);
    chk("nextframe_s0", pos, seg, 7'b0001111);
    go_to(28);
    chk("nextframe_s1", pos, seg, 7'b0001111);

    // Scenario 5: disabled digit keeps frame timing.
    restart(8'h12, 2'b01, 2'b00, 1'b0);
    for (int p = 0; p < 32; p++) begin
      go_to(p);
      chk("en_anode", p, anode,
          ((p % 16) >= 2 && (p % 16) <= 7) ? 2'b10 : 2'b11);
    end

    // Scenario 6: async reset at 3rd DRIVE cycle of slot 1.
    restart(8'h3A, 2'b11, 2'b00, 1'b0);
    go_to(12);
    chk("pre_areset", pos, anode, 2'b01);
    #1;
    reset = 1'b0;
    #1;
    chk("areset_out", pos, pack_out(), {2'b11, 7'h7F, 1'b1, 1'b0, 5'b0});
    @(negedge clk);
    reset = 1'b1;
    pos = -1;
    go_to(1);
    chk("rst2_p1", pos, anode, 2'b11);
    go_to(2);
    chk("rst2_p2", pos, anode, 2'b10);
    go_to(8);
    chk("rst2_p8", pos, anode, 2'b11);
    go_to(10);
    chk("rst2_p10", pos, pack_out(),
        {2'b01, 7'b0000110, 1'b1, 1'b1, 5'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
